// File: rtl/starflux_pkg.sv
//------------------------------------------------------------------------------
// Module : starflux_pkg
// Brief  : Shared sizes, FSM state type and ship bitmap for the ship renderer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package starflux_pkg;

  localparam int SHIP_W = 8;
  localparam int SHIP_H = 8;
  localparam int X_MAX  = 120;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Row-major, MSB first: bit (63 - addr) is the pixel at row addr[5:3],
  // column addr[2:0], column 0 on the left.
  localparam logic [63:0] SHIP_BITMAP = 64'h1818_3C7E_FFFF_DB81;

  // Keep the sprite fully on screen: columns above X_MAX pin to X_MAX.
  function automatic logic [7:0] clamp_x(input logic [7:0] x);
    return (x > 8'(X_MAX)) ? 8'(X_MAX) : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ship_sprite_rom.sv
//------------------------------------------------------------------------------
// Module : ship_sprite_rom
// Brief  : Combinational 64x1 lookup of the ship bitmap mask.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ship_sprite_rom
  import starflux_pkg::*;
(
  input  logic [5:0] i_addr,
  output logic       o_mask
);

  logic [5:0] w_bit_idx;

  assign w_bit_idx = 6'd63 - i_addr;
  assign o_mask    = SHIP_BITMAP[w_bit_idx];

endmodule

`default_nettype wire

// File: rtl/ship_renderer.sv
//------------------------------------------------------------------------------
// Module : ship_renderer
// Brief  : Erases the old 8x8 ship and draws it at its new column on a
//          160x120 VGA frame buffer, one pixel per clock.
// Config : SHIP_SPRITE_EN - when defined, draw pixels come from the ship
//          bitmap (mask-0 pixels are transparent); otherwise a solid block.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ship_renderer
  import starflux_pkg::*;
#(
  parameter logic [6:0] SHIP_Y      = 7'd112,
  parameter logic [2:0] SHIP_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] x_val,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  state_t     r_state;
  logic [5:0] r_cnt;
  logic [7:0] r_drawn_x;
  logic [7:0] r_new_x;
  logic       r_drawn_valid;
  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_busy;

  state_t     w_next_state;
  logic [5:0] w_next_cnt;
  logic [7:0] w_next_drawn_x;
  logic [7:0] w_next_new_x;
  logic       w_next_valid;
  logic [7:0] w_x_clamped;
  logic [7:0] w_col;
  logic [6:0] w_row;
  logic [7:0] w_out_x;
  logic [6:0] w_out_y;
  logic [2:0] w_out_colour;
  logic       w_out_plot;
  logic       w_mask;

  assign w_x_clamped = clamp_x(x_val);

  // Outputs are registered against the *next* state/counter so that the
  // pixel presented in a cycle always belongs to the state shown in that cycle.
  assign w_col = {5'd0, w_next_cnt[2:0]};
  assign w_row = {4'd0, w_next_cnt[5:3]};

`ifdef SHIP_SPRITE_EN
  ship_sprite_rom u_sprite_rom (
    .i_addr (w_next_cnt),
    .o_mask (w_mask)
  );
`else
  assign w_mask = 1'b1;
`endif

  // Next-state, counter and position bookkeeping for the erase/draw passes.
  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_next_drawn_x = r_drawn_x;
    w_next_new_x   = r_new_x;
    w_next_valid   = r_drawn_valid;
    case (r_state)
      IDLE: begin
        if (enable) begin
          if (!r_drawn_valid) begin
            // Nothing on screen yet: skip the erase pass.
            w_next_state = DRAW;
            w_next_new_x = w_x_clamped;
            w_next_cnt   = 6'd0;
          end else if (w_x_clamped != r_drawn_x) begin
            w_next_state = ERASE;
            w_next_new_x = w_x_clamped;
            w_next_cnt   = 6'd0;
          end
        end
      end
      ERASE: begin
        if (r_cnt == 6'd63) begin
          w_next_state = DRAW;
          w_next_cnt   = 6'd0;
        end else begin
          w_next_cnt = r_cnt + 6'd1;
        end
      end
      DRAW: begin
        if (r_cnt == 6'd63) begin
          w_next_state = DONE;
          w_next_cnt   = 6'd0;
        end else begin
          w_next_cnt = r_cnt + 6'd1;
        end
      end
      DONE: begin
        w_next_state   = IDLE;
        w_next_drawn_x = r_new_x;
        w_next_valid   = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Pixel address/colour/strobe for the cycle about to be presented.
  always_comb begin
    w_out_x      = r_vga_x;
    w_out_y      = r_vga_y;
    w_out_colour = r_colour;
    w_out_plot   = 1'b0;
    case (w_next_state)
      ERASE: begin
        w_out_x      = r_drawn_x + w_col;
        w_out_y      = SHIP_Y + w_row;
        w_out_colour = BG_COLOUR;
        w_out_plot   = 1'b1;
      end
      DRAW: begin
        w_out_x      = w_next_new_x + w_col;
        w_out_y      = SHIP_Y + w_row;
        w_out_colour = SHIP_COLOUR;
        w_out_plot   = w_mask;
      end
      default: w_out_plot = 1'b0;
    endcase
  end

  // State and registered outputs; reset aborts any pass in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= 6'd0;
      r_drawn_x     <= 8'd0;
      r_new_x       <= 8'd0;
      r_drawn_valid <= 1'b0;
      r_vga_x       <= 8'd0;
      r_vga_y       <= 7'd0;
      r_colour      <= 3'd0;
      r_plot        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_drawn_x     <= w_next_drawn_x;
      r_new_x       <= w_next_new_x;
      r_drawn_valid <= w_next_valid;
      r_vga_x       <= w_out_x;
      r_vga_y       <= w_out_y;
      r_colour      <= w_out_colour;
      r_plot        <= w_out_plot;
      r_busy        <= (w_next_state != IDLE);
    end
  end

  assign vga_x  = r_vga_x;
  assign vga_y  = r_vga_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign busy   = r_busy;

endmodule

`default_nettype wire

// File: doc/ship_renderer.md
SHIP_RENDERER -- requirements
Module: ship_renderer

Interface
REQ-001 SHALL expose parameter SHIP_Y, default 7'd112, meaning the top row of the ship sprite on the 160x120 VGA grid.
REQ-002 SHALL expose parameter SHIP_COLOUR, default 3'b111, meaning the sprite pixel colour.
REQ-003 SHALL expose parameter BG_COLOUR, default 3'b000, meaning the erase colour.
REQ-004 clock  input  1  50 MHz board clock; the only clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  renderer may start a new frame while high.
REQ-007 x_val  input  8  ship left column from the movement stage; valid range 0..120.
REQ-008 vga_x  output  8  pixel column to the VGA adapter.
REQ-009 vga_y  output  7  pixel row to the VGA adapter.
REQ-010 colour  output  3  pixel colour to the VGA adapter.
REQ-011 plot  output  1  write strobe; the adapter writes (vga_x, vga_y, colour) on every cycle where plot=1.
REQ-012 busy  output  1  high while an erase or draw pass is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, ERASE, DRAW, DONE.
REQ-014 IDLE->ERASE SHALL occur when enable=1, drawn_valid=1 and x_clamped != drawn_x; on this transition new_x <= x_clamped and cnt <= 0.
REQ-015 IDLE->DRAW SHALL occur when enable=1 and drawn_valid=0 (first draw after reset); the erase pass is skipped.
REQ-016 x_clamped SHALL be x_val when x_val <= 120, and 120 otherwise.
REQ-017 SHALL keep a 6-bit pixel counter cnt: col = cnt[2:0], row = cnt[5:3]; a pass covers an 8x8 region in 64 cycles, row-major.
REQ-018 In ERASE: vga_x = drawn_x + col, vga_y = SHIP_Y + row, colour = BG_COLOUR, plot = 1 on all 64 cycles; after cnt = 63 go to DRAW with cnt <= 0.
REQ-019 In DRAW: vga_x = new_x + col, vga_y = SHIP_Y + row, colour = SHIP_COLOUR, plot = sprite mask bit; after cnt = 63 go to DONE.
REQ-020 DONE SHALL last one cycle with plot = 0, set drawn_x <= new_x and drawn_valid <= 1, then return to IDLE.
REQ-021 Changes on x_val during ERASE, DRAW or DONE SHALL be ignored; only the value captured at pass start is used. The next change is detected in IDLE.
REQ-022 enable deasserted mid-pass SHALL NOT abort the pass; it only blocks new starts from IDLE.
REQ-023 A pass, once started, SHALL complete: erase + draw takes 129 cycles from pass start to return to IDLE, and a first draw takes 65.
REQ-024 x_val equal to drawn_x in IDLE SHALL produce no activity.
REQ-025 busy SHALL be 1 exactly in ERASE, DRAW and DONE.
REQ-026 Pixel addition SHALL be 8-bit unsigned; with x_clamped <= 120 no column exceeds 127, so there is no wrap.

Reset
REQ-027 On reset: state = IDLE; cnt, drawn_x, new_x = 0; drawn_valid = 0; plot = 0; busy = 0; vga_x = 0; vga_y = 0; colour = 0.
REQ-028 Reset asserted mid-pass SHALL abort immediately. The next pass after release SHALL be a first draw with no erase.

Configuration
REQ-029 Macro SHIP_SPRITE_EN: when defined, the DRAW mask SHALL come from the 8x8 ship bitmap, and mask-0 pixels SHALL have plot = 0 (transparent).
REQ-030 When SHIP_SPRITE_EN is undefined, the mask SHALL be all ones: a solid 8x8 SHIP_COLOUR block.

Structure
REQ-031 Shared package starflux_pkg SHALL hold SHIP_W = 8, SHIP_H = 8, X_MAX = 120, the state enum type and the 64-bit ship bitmap constant.
REQ-032 Sub-module ship_sprite_rom (6-bit address in, 1-bit mask out, combinational) SHALL hold the bitmap. It SHALL be instantiated only under SHIP_SPRITE_EN.

Verification
REQ-033 Reset release, enable=1, x_val=40 -> DRAW only: 64 cycles with vga_x 40..47, vga_y 112..119; busy stays high for 65 cycles; drawn_x=40.
REQ-034 After REQ-033, x_val=41 -> 64 erase plots at x 40..47 with colour 000, then 64 draw cycles at x 41..48, then idle.
REQ-035 x_val=200 -> draw at x 120..127 and no plot with vga_x > 127; then x_val=120 -> no activity.
REQ-036 During ERASE, toggle x_val 41->60 -> pass completes at 41; one further pass then moves the ship to 60.
REQ-037 Assert reset at cnt=30 of DRAW -> plot=0 at once; after release with x_val=10, a first draw only at x 10..17.
REQ-038 Build with and without SHIP_SPRITE_EN -> plot count in DRAW equals the bitmap popcount in one build and 64 in the other.
